// File: rtl/bp_be_stall_histogram.sv
// Stall-attribution profiler for the BlackParrot BE: a shadow pipeline of stall-reason vectors
// feeds saturating per-reason, unknown, instret and cycle counters behind a 1-cycle read port.
// Optional sticky saturation flags are built when BP_STALL_HIST_OVF_EN is defined.
module bp_be_stall_histogram #(
   parameter int num_reasons_p = 21,
   parameter int num_stages_p  = 8,
   parameter int cnt_width_p   = 32,
   parameter int addr_width_lp = (num_reasons_p + 3 > 1) ? $clog2(num_reasons_p + 3) : 1
) (
   input  logic                                   clk_i,
   input  logic                                   reset_li,
   input  logic                                   freeze_i,
   input  logic [num_stages_p*num_reasons_p-1:0]  stall_i,
   input  logic                                   commit_v_i,
   input  logic                                   clear_i,
   input  logic                                   rd_v_i,
   input  logic [addr_width_lp-1:0]               rd_addr_i,
   output logic                                   rd_v_o,
   output logic [cnt_width_p-1:0]                 rd_data_o,
   output logic [num_reasons_p+2:0]               ovf_o
);

   localparam int num_cnt_lp      = num_reasons_p + 3;
   localparam int unknown_idx_lp  = num_reasons_p;
   localparam int instret_idx_lp  = num_reasons_p + 1;
   localparam int cycle_idx_lp    = num_reasons_p + 2;
   localparam int idx_width_lp    = $clog2(num_cnt_lp);

   logic                     flush;
   logic [num_reasons_p-1:0] stage_r [num_stages_p];
   logic [num_reasons_p-1:0] stage_n [num_stages_p];
   logic [num_reasons_p-1:0] final_vec;
   logic [idx_width_lp-1:0]  reason_idx;
   logic [num_cnt_lp-1:0]    inc;
   logic [cnt_width_p-1:0]   cnt_r [num_cnt_lp];
   logic [cnt_width_p-1:0]   rd_mux;
   logic                     rd_v_r;
   logic [cnt_width_p-1:0]   rd_data_r;

   assign flush = freeze_i | clear_i;

   // Shadow pipeline: reasons accumulate as they ride toward the attribution stage.
   assign stage_n[0] = flush ? '0 : stall_i[0 +: num_reasons_p];
   for (genvar s = 1; s < num_stages_p; s++) begin : g_stage
      assign stage_n[s] = flush ? '0
                        : (stage_r[s-1] | stall_i[s*num_reasons_p +: num_reasons_p]);
   end

   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li) begin
         for (int s = 0; s < num_stages_p; s++) stage_r[s] <= '0;
      end else begin
         // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
         for (int s = 0; s < num_stages_p; s++) stage_r[s] <= stage_n[s];
      end
   end

   assign final_vec = stage_r[num_stages_p-1];

   always_comb begin
      // NOTE: default first so no path leaves reason_idx unassigned (no latch).
      reason_idx = '0;
      for (int i = num_reasons_p - 1; i >= 0; i--) begin
         if (final_vec[i]) reason_idx = i[idx_width_lp-1:0];
      end
   end

   // Exactly one of instret/reason/unknown plus the cycle counter per live cycle.
   always_comb begin
      inc = '0;
      if (!flush) begin
         inc[cycle_idx_lp] = 1'b1;
         if (commit_v_i)       inc[instret_idx_lp] = 1'b1;
         else if (|final_vec)  inc[reason_idx]     = 1'b1;
         else                  inc[unknown_idx_lp] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li) begin
         // NOTE: the counter bank is flops, not RAM, so it is reset like any register.
         for (int i = 0; i < num_cnt_lp; i++) cnt_r[i] <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < num_cnt_lp; i++) cnt_r[i] <= '0;
      end else begin
         for (int i = 0; i < num_cnt_lp; i++) begin
            if (inc[i] && !(&cnt_r[i])) cnt_r[i] <= cnt_r[i] + 1'b1;
         end
      end
   end

   // Unmatched addresses fall through to zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < num_cnt_lp; i++) begin
         if (rd_addr_i == i[addr_width_lp-1:0]) rd_mux = cnt_r[i];
      end
   end

   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li) begin
         rd_v_r    <= 1'b0;
         rd_data_r <= '0;
      end else begin
         rd_v_r <= rd_v_i;
         if (rd_v_i) rd_data_r <= rd_mux;
      end
   end

   assign rd_v_o    = rd_v_r;
   assign rd_data_o = rd_data_r;

`ifdef BP_STALL_HIST_OVF_EN
   logic [num_cnt_lp-1:0] sat_vec;
   logic [num_cnt_lp-1:0] ovf_r;

   always_comb begin
      sat_vec = '0;
      for (int i = 0; i < num_cnt_lp; i++) sat_vec[i] = &cnt_r[i];
   end

   // Sticky: an increment attempted while pinned at full scale.
   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li)    ovf_r <= '0;
      else if (clear_i) ovf_r <= '0;
      else              ovf_r <= ovf_r | (inc & sat_vec);
   end

   assign ovf_o = ovf_r;
`else
   assign ovf_o = '0;
`endif

endmodule

// File: tb/tb_bp_be_stall_histogram.sv
// Self-checking bench for bp_be_stall_histogram: an arrival-time event model checked every
// cycle, plus directed scenarios with hand-computed read values.
module tb_bp_be_stall_histogram;

   localparam int R    = 21;
   localparam int S    = 8;
   localparam int C    = 4;
   localparam int N    = R + 3;
   localparam int AW   = 5;
   localparam int UNK  = R;
   localparam int INS  = R + 1;
   localparam int CYC  = R + 2;
   localparam int MAXV = (1 << C) - 1;
`ifdef BP_STALL_HIST_OVF_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   logic           clk_i      = 1'b0;
   logic           reset_li   = 1'b0;
   logic           freeze_i   = 1'b0;
   logic [S*R-1:0] stall_i    = '0;
   logic           commit_v_i = 1'b0;
   logic           clear_i    = 1'b0;
   logic           rd_v_i     = 1'b0;
   logic [AW-1:0]  rd_addr_i  = '0;
   logic           rd_v_o;
   logic [C-1:0]   rd_data_o;
   logic [N-1:0]   ovf_o;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk_i = ~clk_i;

   bp_be_stall_histogram #(
      .num_reasons_p(R),
      .num_stages_p (S),
      .cnt_width_p  (C),
      .addr_width_lp(AW)
   ) dut (
      .clk_i     (clk_i),
      .reset_li  (reset_li),
      .freeze_i  (freeze_i),
      .stall_i   (stall_i),
      .commit_v_i(commit_v_i),
      .clear_i   (clear_i),
      .rd_v_i    (rd_v_i),
      .rd_addr_i (rd_addr_i),
      .rd_v_o    (rd_v_o),
      .rd_data_o (rd_data_o),
      .ovf_o     (ovf_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: a reason injected at stage s in model cycle t lands on the attribution point
   // at cycle t+S-s; freeze/clear throws away everything still in flight.
   int           m_cnt [N];
   logic [N-1:0] m_ovf = '0;
   bit           m_rd_v = 1'b0;
   int           m_rd_data = 0;
   logic [R-1:0] arrivals [int];
   int           now = 0;

   task automatic bump(input int i);
      if (m_cnt[i] == MAXV) begin
`ifdef BP_STALL_HIST_OVF_EN
         m_ovf[i] = 1'b1;
`endif
      end else begin
         m_cnt[i] = m_cnt[i] + 1;
      end
   endtask

   always @(posedge clk_i) begin : model
      logic [R-1:0] fin;
      logic [R-1:0] sl;
      int           key;
      int           idx;
      if (!reset_li) begin
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
         m_ovf = '0; m_rd_v = 1'b0; m_rd_data = 0;
         arrivals.delete();
         now = 0;
      end else begin
         fin = arrivals.exists(now) ? arrivals[now] : '0;
         m_rd_v = rd_v_i;
         if (rd_v_i) m_rd_data = (int'(rd_addr_i) < N) ? m_cnt[rd_addr_i] : 0;
         if (freeze_i || clear_i) begin
            arrivals.delete();
            if (clear_i) begin
               for (int i = 0; i < N; i++) m_cnt[i] = 0;
               m_ovf = '0;
            end
         end else begin
            for (int s = 0; s < S; s++) begin
               sl = stall_i[s*R +: R];
               if (sl != '0) begin
                  key = now + S - s;
                  arrivals[key] = (arrivals.exists(key) ? arrivals[key] : '0) | sl;
               end
            end
            idx = UNK;
            if (commit_v_i) idx = INS;
            else begin
               for (int b = 0; b < R; b++) begin
                  if (fin[b]) begin idx = b; break; end
               end
            end
            bump(idx);
            bump(CYC);
            if (arrivals.exists(now)) arrivals.delete(now);
         end
         now++;
      end
   end

   always @(negedge clk_i) begin
      if (chk_en) begin
         check("rd_v", rd_v_o, m_rd_v);
         if (m_rd_v) check("rd_data", rd_data_o, m_rd_data);
         check("ovf", ovf_o, m_ovf);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic pulse(input int s, input int b0, input int b1);
      stall_i = '0;
      stall_i[s*R + b0] = 1'b1;
      if (b1 >= 0) stall_i[s*R + b1] = 1'b1;
      @(negedge clk_i);
      stall_i = '0;
   endtask

   task automatic rd(input int a, input int exp, input string name);
      rd_v_i = 1'b1;
      rd_addr_i = AW'(a);
      @(negedge clk_i);
      rd_v_i = 1'b0;
      check(name, rd_data_o, exp);
   endtask

   task automatic do_clear;
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk_i);
      #1;
      check("rst_rd_v", rd_v_o, 0);
      check("rst_rd_data", rd_data_o, 0);
      check("rst_ovf", ovf_o, 0);
      @(negedge clk_i);
      reset_li = 1'b1;
      chk_en = 1'b1;

      // Ten idle cycles after reset, read back under freeze so nothing moves.
      cyc(10);
      freeze_i = 1'b1;
      rd(CYC, 10, "idle_cycles");
      rd(UNK, 10, "idle_unknown");
      rd(INS, 0, "idle_instret");
      for (int i = 0; i < R; i++) rd(i, 0, "idle_reason");
      freeze_i = 1'b0;

      // Stage 3 bit 5 in cycle 0 reaches final in cycle 5.
      do_clear;
      pulse(3, 5, -1);
      cyc(4);
      rd(5, 0, "lat_before");
      rd(5, 1, "lat_reason5");
      rd(UNK, 6, "lat_unknown");

      // Bits 7 and 2 together: priority picks 2.
      do_clear;
      pulse(0, 7, 2);
      cyc(8);
      freeze_i = 1'b1;
      rd(2, 1, "prio_reason2");
      rd(7, 0, "prio_reason7");
      freeze_i = 1'b0;

      // Same final vector with a commit: instret only.
      do_clear;
      pulse(0, 7, 2);
      cyc(7);
      commit_v_i = 1'b1;
      cyc(1);
      commit_v_i = 1'b0;
      freeze_i = 1'b1;
      rd(INS, 1, "commit_instret");
      rd(2, 0, "commit_reason2");
      rd(UNK, 8, "commit_unknown");
      rd(CYC, 9, "commit_cycles");
      freeze_i = 1'b0;

      // Twenty attributions to reason 0 saturate at 15.
      do_clear;
      stall_i[(S-1)*R] = 1'b1;
      cyc(20);
      stall_i = '0;
      cyc(1);
      freeze_i = 1'b1;
      rd(0, MAXV, "sat_reason0");
      check("sat_ovf0", ovf_o[0], OVF_EXP);
      freeze_i = 1'b0;
      do_clear;
      freeze_i = 1'b1;
      rd(0, 0, "clr_reason0");
      check("clr_ovf0", ovf_o[0], 0);
      freeze_i = 1'b0;

      // Read, clear and increment in one cycle; then freeze holds the cycle counter.
      do_clear;
      cyc(3);
      clear_i = 1'b1;
      rd_v_i = 1'b1;
      rd_addr_i = AW'(UNK);
      @(negedge clk_i);
      check("clr_same_old", rd_data_o, 3);
      clear_i = 1'b0;
      @(negedge clk_i);
      check("clr_same_new", rd_data_o, 0);
      rd_v_i = 1'b0;
      freeze_i = 1'b1;
      cyc(4);
      rd(CYC, 1, "frz_cycles");
      freeze_i = 1'b0;
      rd(CYC, 1, "unfrz_cycles");

      // Freeze mid-flight discards the in-flight reason.
      do_clear;
      pulse(0, 3, -1);
      cyc(2);
      freeze_i = 1'b1;
      cyc(1);
      freeze_i = 1'b0;
      cyc(10);
      freeze_i = 1'b1;
      rd(3, 0, "frz_discard");
      rd(30, 0, "oob_addr30");
      rd(24, 0, "oob_addr24");
      freeze_i = 1'b0;

      // Reset with a read pending.
      rd_v_i = 1'b1;
      rd_addr_i = AW'(CYC);
      #2;
      reset_li = 1'b0;
      rd_v_i = 1'b0;
      #1;
      check("rst_mid_rd_v", rd_v_o, 0);
      check("rst_mid_rd_data", rd_data_o, 0);
      @(negedge clk_i);
      reset_li = 1'b1;
      cyc(3);
      freeze_i = 1'b1;
      rd(CYC, 3, "post_rst_cycles");
      freeze_i = 1'b0;

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
